// File: rtl/sort_controller_pkg.sv
// Shared types and constants for the sort controller and its comparator.
package sort_controller_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SORT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/sort_controller_cmp.sv
// Unsigned magnitude comparator; the only comparison resource in the sorter.
module comparator_8bit
  import sort_controller_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              gt_o,
  output logic              lt_o,
  output logic              eq_o
);

  assign gt_o = (a_i > b_i);
  assign lt_o = (a_i < b_i);
  assign eq_o = (a_i == b_i);

endmodule

// File: rtl/sort_controller.sv
// Load DEPTH bytes, bubble-sort them in place one compare per cycle, then drain
// them through a valid/ready port.
module sort_controller
  import sort_controller_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              descend,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] LAST_CMP = IDX_W'(DEPTH - 2);

  state_e            state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  pass_q;
  logic [IDX_W-1:0]  cmp_q;
  logic              descend_q;
  logic [DATA_W-1:0] elem_q [DEPTH];
  logic              in_ready_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              busy_q;
  logic              done_q;

  logic [IDX_W-1:0]  idx_nxt;
  logic [IDX_W-1:0]  cmp_nxt;
  logic [DATA_W-1:0] lhs_d;
  logic [DATA_W-1:0] rhs_d;
  logic              cmp_gt;
  logic              cmp_lt;
  logic              cmp_eq;
  logic              swap_d;

  assign idx_nxt = idx_q + IDX_W'(1);
  assign cmp_nxt = cmp_q + IDX_W'(1);
  assign lhs_d   = elem_q[cmp_q];
  assign rhs_d   = elem_q[cmp_nxt];

  comparator_8bit u_cmp (
    .a_i  (lhs_d),
    .b_i  (rhs_d),
    .gt_o (cmp_gt),
    .lt_o (cmp_lt),
    .eq_o (cmp_eq)
  );

  // Equal keys never swap, which keeps the sort stable.
  assign swap_d = !cmp_eq && (descend_q ? cmp_lt : cmp_gt);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      pass_q      <= '0;
      cmp_q       <= '0;
      descend_q   <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        elem_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            descend_q  <= descend;
            idx_q      <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (in_valid && in_ready_q) begin
            elem_q[idx_q] <= in_data;
            if (idx_q == LAST_IDX) begin
              idx_q      <= '0;
              pass_q     <= '0;
              cmp_q      <= '0;
              in_ready_q <= 1'b0;
              state_q    <= ST_SORT;
            end else begin
              idx_q <= idx_nxt;
            end
          end
        end
        ST_SORT: begin
          if (swap_d) begin
            elem_q[cmp_q]   <= rhs_d;
            elem_q[cmp_nxt] <= lhs_d;
          end
          if (cmp_q == LAST_CMP) begin
            cmp_q <= '0;
            if (pass_q == LAST_CMP) begin
              pass_q  <= '0;
              state_q <= ST_DRAIN;
            end else begin
              pass_q <= pass_q + IDX_W'(1);
            end
          end else begin
            cmp_q <= cmp_nxt;
          end
        end
        ST_DRAIN: begin
          // First DRAIN cycle registers element 0 after the last swap has landed.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            out_data_q  <= elem_q[idx_q];
          end else if (out_ready) begin
            if (idx_q == LAST_IDX) begin
              idx_q       <= '0;
              out_valid_q <= 1'b0;
              out_data_q  <= '0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= ST_IDLE;
            end else begin
              idx_q      <= idx_nxt;
              out_data_q <= elem_q[idx_nxt];
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_sort_controller.sv
// Randomized bench for sort_controller against a stable-sort reference model.
module tb_sort_controller;

  localparam int DEPTH   = 4;
  localparam int EXP_LAT = 1 + DEPTH + (DEPTH - 1) * (DEPTH - 1) + 1;
  localparam int EXP_GAP = (DEPTH - 1) * (DEPTH - 1) + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       descend = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready = 1'b0;
  logic       busy;
  logic       done;

  sort_controller #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .descend   (descend),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int         n_pass = 0;
  int         n_total = 0;
  logic [7:0] exp_q [$];
  logic       done_due = 1'b0;
  logic       started = 1'b0;
  logic       stall_prev = 1'b0;
  logic [7:0] held_data = 8'h00;

  logic [7:0] job_v [DEPTH];
  logic [7:0] got_v [DEPTH];
  logic [7:0] lit_v [DEPTH];
  int         lat;
  int         gap;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stable sort: each new key goes after every key already placed that it
  // does not strictly precede.
  task automatic model_push(input logic desc);
    logic [7:0] r [$];
    int pos;
    r = {};
    for (int i = 0; i < DEPTH; i++) begin
      pos = r.size();
      for (int k = 0; k < r.size(); k++) begin
        if (desc ? (r[k] < job_v[i]) : (r[k] > job_v[i])) begin
          pos = k;
          break;
        end
      end
      r.insert(pos, job_v[i]);
    end
    foreach (r[i]) exp_q.push_back(r[i]);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic chk_lit(input string tag);
    for (int i = 0; i < DEPTH; i++) chk(tag, got_v[i], lit_v[i]);
  endtask

  // Runs one job from job_v; abort=1 resets the DUT during comparison 4.
  task automatic run_job(input logic desc, input logic gaps, input logic bp,
                         input logic poke, input logic rnd_ready, input logic abort);
    int ecount, loaded, last_load_e, ndr, guard, stall;
    logic rdy, hs, seen;
    lat = -1;
    gap = -1;
    start = 1'b1;
    descend = desc;
    model_push(desc);
    step();
    start = 1'b0;
    descend = 1'b0;
    ecount = 1;
    loaded = 0;
    last_load_e = 0;
    guard = 0;
    while (loaded < DEPTH && guard < 200) begin
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data = job_v[loaded];
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b0;
      if (poke && loaded == 1) begin
        start = 1'b1;
        descend = 1'b1;
      end
      rdy = in_ready;
      hs = in_valid && rdy;
      step();
      ecount++;
      guard++;
      start = 1'b0;
      descend = 1'b0;
      if (hs) begin
        loaded++;
        if (loaded == DEPTH) last_load_e = ecount;
      end
    end
    in_valid = 1'b0;
    if (loaded != DEPTH) chk("load_timeout", loaded, DEPTH);
    if (abort) begin
      repeat (3) step();
      reset = 1'b1;
      exp_q.delete();
      done_due = 1'b0;
      step();
      reset = 1'b0;
      chk_quiet("abort");
      return;
    end
    ndr = 0;
    guard = 0;
    stall = 0;
    seen = 1'b0;
    while (ndr < DEPTH && guard < 500) begin
      if (out_valid && !seen) begin
        seen = 1'b1;
        lat = ecount;
        gap = ecount - last_load_e;
        if (bp) stall = 5;
      end
      if (stall > 0) begin
        out_ready = 1'b0;
        stall--;
      end else begin
        out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      if (poke && ndr == 1) begin
        start = 1'b1;
        descend = 1'b1;
      end
      if (out_valid && out_ready) begin
        got_v[ndr] = out_data;
        ndr++;
      end
      step();
      ecount++;
      guard++;
      start = 1'b0;
      descend = 1'b0;
    end
    out_ready = 1'b0;
    if (ndr != DEPTH) chk("drain_timeout", ndr, DEPTH);
    chk("done_pulse", done, 1);
    chk("busy_after_drain", busy, 0);
    step();
    chk("done_single", done, 0);
  endtask

  // Per-cycle scoreboard: drained order, hold under stall, done timing.
  always @(negedge clk) begin
    if (started) begin
      chk("done", done, done_due);
      done_due = 1'b0;
      if (!busy) chk("idle_outputs", {in_ready, out_valid}, 0);
      if (stall_prev) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, held_data);
      end
      stall_prev = out_valid && !out_ready && !reset;
      held_data = out_data;
      if (out_valid && out_ready && !reset) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", 1, 0);
        end else begin
          chk("out_data", out_data, exp_q.pop_front());
          if (exp_q.size() == 0) done_due = 1'b1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start = 1'b1;
    descend = 1'b1;
    step();
    step();
    chk_quiet("reset");
    reset = 1'b0;
    start = 1'b0;
    descend = 1'b0;
    step();
    chk("reset_start_priority", busy, 0);
    started = 1'b1;

    job_v = '{8'h08, 8'h10, 8'h03, 8'hFF};
    run_job(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    lit_v = '{8'h03, 8'h08, 8'h10, 8'hFF};
    chk_lit("asc_order");
    chk("asc_latency", lat, EXP_LAT);
    chk("asc_sort_gap", gap, EXP_GAP);
    $display("job asc 08,10,03,FF -> %h %h %h %h lat=%0d", got_v[0], got_v[1], got_v[2], got_v[3], lat);

    run_job(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    lit_v = '{8'hFF, 8'h10, 8'h08, 8'h03};
    chk_lit("desc_order");
    $display("job desc 08,10,03,FF -> %h %h %h %h", got_v[0], got_v[1], got_v[2], got_v[3]);

    job_v = '{8'h05, 8'h05, 8'h05, 8'h05};
    run_job(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    lit_v = '{8'h05, 8'h05, 8'h05, 8'h05};
    chk_lit("equal_order");
    chk("equal_sort_gap", gap, EXP_GAP);
    $display("job equal 05x4 -> %h %h %h %h gap=%0d", got_v[0], got_v[1], got_v[2], got_v[3], gap);

    job_v = '{8'h08, 8'h10, 8'h03, 8'hFF};
    run_job(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    lit_v = '{8'h03, 8'h08, 8'h10, 8'hFF};
    chk_lit("bp_order");
    $display("job backpressure -> %h %h %h %h", got_v[0], got_v[1], got_v[2], got_v[3]);

    job_v = '{8'h40, 8'h20, 8'h30, 8'h10};
    run_job(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    $display("job aborted by reset mid-sort");
    job_v = '{8'h01, 8'h00, 8'h02, 8'h00};
    run_job(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    lit_v = '{8'h00, 8'h00, 8'h01, 8'h02};
    chk_lit("post_reset_order");
    $display("job after reset 01,00,02,00 -> %h %h %h %h", got_v[0], got_v[1], got_v[2], got_v[3]);

    job_v = '{8'h08, 8'h10, 8'h03, 8'hFF};
    run_job(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    lit_v = '{8'h03, 8'h08, 8'h10, 8'hFF};
    chk_lit("start_busy_order");
    $display("job start-while-busy -> %h %h %h %h", got_v[0], got_v[1], got_v[2], got_v[3]);

    for (int j = 0; j < 25; j++) begin
      logic d;
      for (int i = 0; i < DEPTH; i++) begin
        case ($urandom_range(0, 3))
          0: job_v[i] = 8'h00;
          1: job_v[i] = 8'hFF;
          2: job_v[i] = 8'($urandom_range(1, 4));
          default: job_v[i] = 8'($urandom);
        endcase
      end
      d = 1'($urandom_range(0, 1));
      run_job(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      $display("random job %0d desc=%0d in=%h %h %h %h out=%h %h %h %h", j, d,
               job_v[0], job_v[1], job_v[2], job_v[3], got_v[0], got_v[1], got_v[2], got_v[3]);
    end

    step();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sort_controller.md
SORT_CONTROLLER -- requirements
Module: sort_controller

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of 8-bit elements per sort job, legal range 2..8.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  job request; accepted only in IDLE.
REQ-005 SHALL have port descend  input  1  order select, sampled with an accepted start: 0 ascending, 1 descending.
REQ-006 SHALL have port in_valid  input  1  load-data qualifier.
REQ-007 SHALL have port in_data  input  8  element being loaded.
REQ-008 SHALL have port in_ready  output  1  high only in LOAD.
REQ-009 SHALL have port out_valid  output  1  high only in DRAIN.
REQ-010 SHALL have port out_data  output  8  sorted element currently presented.
REQ-011 SHALL have port out_ready  input  1  downstream acceptance.
REQ-012 SHALL have port busy  output  1  high in any state except IDLE.
REQ-013 SHALL have port done  output  1  one-cycle pulse on the cycle after the last element is drained.

Function
REQ-014 SHALL implement the state machine IDLE -> LOAD -> SORT -> DRAIN -> IDLE.
REQ-015 IDLE: start=1 SHALL latch descend, clear the element index, and enter LOAD on the next cycle.
REQ-016 LOAD: each cycle with in_valid&in_ready SHALL write in_data to element[index] and increment index.
REQ-017 LOAD: the DEPTH-th transfer SHALL move the block to SORT, and index SHALL reset to 0.
REQ-018 SORT: SHALL perform bubble sort with exactly one comparison of element[j] and element[j+1] per cycle.
REQ-019 SORT: SHALL run fixed (DEPTH-1) passes of (DEPTH-1) comparisons each, with j = 0..DEPTH-2 per pass; for DEPTH=4 this is 9 cycles, with no early exit.
REQ-020 Swap rule, ascending: SHALL swap both elements in the same cycle when Greater is asserted.
REQ-021 Swap rule, descending: SHALL swap both elements in the same cycle when Less is asserted.
REQ-022 When Equal is asserted the block SHALL never swap, so equal keys keep their load order.
REQ-023 The SORT-to-DRAIN transition SHALL occur on the cycle after the final comparison.
REQ-024 DRAIN: out_data SHALL equal element[index], and out_valid&out_ready SHALL advance index.
REQ-025 DRAIN: out_data and out_valid SHALL hold stable while out_ready=0.
REQ-026 The final DRAIN handshake SHALL return the block to IDLE and assert done for exactly one cycle.
REQ-027 start outside IDLE SHALL be ignored, with no effect on state or latched descend.
REQ-028 in_valid outside LOAD SHALL be ignored, and elements SHALL not change.
REQ-029 out_ready outside DRAIN SHALL have no effect.
REQ-030 Comparison SHALL be unsigned 8-bit; values 8'h00 and 8'hFF are legal keys with no wrap behaviour.
REQ-031 Latency from accepted start to first out_valid SHALL be 1 + DEPTH load handshakes + (DEPTH-1)^2 + 1 cycles, assuming in_valid is held high.

Reset
REQ-032 reset=1 at a clock edge SHALL force IDLE from any state, including mid-LOAD, mid-SORT and mid-DRAIN, and abandon the job.
REQ-033 On reset, all outputs SHALL clear: in_ready=0, out_valid=0, out_data=8'h00, busy=0, done=0.
REQ-034 On reset, index, pass counter, compare counter, latched descend and all elements SHALL clear to 0.
REQ-035 reset SHALL take priority over start asserted in the same cycle.

Structure
REQ-036 State encoding (IDLE, LOAD, SORT, DRAIN) and the 8-bit data width constant SHALL live in a shared package.
REQ-037 SHALL instantiate exactly one comparator_8bit, driven by element[j] and element[j+1], as its sole comparison resource.
REQ-038 SHALL contain no other comparison logic on element data.

Verification
REQ-039 Ascending sort: load 08,10,03,FF with descend=0 -> drain order 03,08,10,FF; first out_valid 15 cycles after start accepted; done pulses once.
REQ-040 Descending sort: load 08,10,03,FF with descend=1 -> drain order FF,10,08,03.
REQ-041 Equal keys: load 05,05,05,05 -> drain order 05,05,05,05, no swap observed, SORT lasts exactly 9 cycles.
REQ-042 Backpressure: hold out_ready=0 for 5 cycles in DRAIN -> out_data/out_valid unchanged; each element emitted exactly once.
REQ-043 Reset mid-SORT: assert reset during comparison 4 -> next cycle IDLE, all outputs 0; a new job on 01,00,02,00 then drains 00,00,01,02.
REQ-044 start while busy: pulse start and descend=1 during LOAD and DRAIN -> no state change, and original ascending order is kept.
